// File: rtl/ws2812_frame_tx.sv
// WS2812 frame transmitter: fetches NUM_LEDS GRB words from an address-indexed mux,
// serialises them MSB first onto dout, then holds a low latch period and pulses done.
module ws2812_frame_tx #(
    parameter int unsigned NUM_LEDS = 4,
    parameter int unsigned T0H      = 20,
    parameter int unsigned T1H      = 40,
    parameter int unsigned TBIT     = 63,
    parameter int unsigned TRESET   = 3000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic [7:0]  led_addr,
    input  logic [23:0] led_data,
    output logic        dout,
    output logic        busy,
    output logic        done
);
    localparam int unsigned BW = (TBIT > 1) ? $clog2(TBIT) : 1;
    localparam int unsigned RW = (TRESET > 1) ? $clog2(TRESET) : 1;
    localparam logic [BW-1:0] BitLast   = BW'(TBIT - 1);
    localparam logic [BW-1:0] HighOne   = BW'(T1H);
    localparam logic [BW-1:0] HighZero  = BW'(T0H);
    localparam logic [RW-1:0] LatchLast = RW'(TRESET - 1);
    localparam logic [7:0]    LedLast   = 8'(NUM_LEDS - 1);

    typedef enum logic [1:0] {StIdle, StPrime, StSend, StLatch} state_e;

    state_e         state_q, state_d;
    logic           prime_q;
    logic [BW-1:0]  bcnt_q;
    logic [4:0]     bidx_q;
    logic [7:0]     lidx_q;
    logic [7:0]     addr_q;
    logic [23:0]    shreg_q;
    logic [23:0]    nxt_q;
    logic           fetch1_q, fetch2_q;
    logic [RW-1:0]  rcnt_q;
    logic           done_q;

    logic bit_end, word_end, last_led;

    assign bit_end  = (bcnt_q == BitLast);
    assign word_end = bit_end && (bidx_q == 5'd0);
    assign last_led = (lidx_q == LedLast);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // A start coinciding with the done pulse is dropped; a new frame needs a fresh request.
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:  if (start && !done_q) state_d = StPrime;
            StPrime: if (prime_q) state_d = StSend;
            StSend:  if (word_end && last_led) state_d = StLatch;
            StLatch: if (rcnt_q == LatchLast) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        dout = 1'b0;
        if (state_q == StSend) begin
            dout = (bcnt_q < (shreg_q[23] ? HighOne : HighZero));
        end
        busy = (state_q != StIdle);
    end

    assign led_addr = addr_q;
    assign done     = done_q;

    // The mux is registered upstream, so a fetched word is captured two cycles after
    // led_addr moves (fetch1 -> fetch2 -> nxt).
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prime_q  <= 1'b0;
            bcnt_q   <= '0;
            bidx_q   <= 5'd23;
            lidx_q   <= 8'd0;
            addr_q   <= 8'd0;
            shreg_q  <= 24'd0;
            nxt_q    <= 24'd0;
            fetch1_q <= 1'b0;
            fetch2_q <= 1'b0;
            rcnt_q   <= '0;
            done_q   <= 1'b0;
        end else begin
            done_q   <= 1'b0;
            fetch1_q <= 1'b0;
            fetch2_q <= fetch1_q;
            if (fetch2_q) begin
                nxt_q <= led_data;
            end
            case (state_q)
                StIdle: begin
                    prime_q <= 1'b0;
                    bcnt_q  <= '0;
                    bidx_q  <= 5'd23;
                    lidx_q  <= 8'd0;
                    addr_q  <= 8'd0;
                    rcnt_q  <= '0;
                end
                StPrime: begin
                    prime_q <= 1'b1;
                    if (prime_q) begin
                        shreg_q <= led_data;
                        if (NUM_LEDS > 1) begin
                            addr_q   <= 8'd1;
                            fetch1_q <= 1'b1;
                        end
                    end
                end
                StSend: begin
                    if (bit_end) begin
                        bcnt_q <= '0;
                        if (bidx_q == 5'd0) begin
                            bidx_q <= 5'd23;
                            if (!last_led) begin
                                shreg_q <= nxt_q;
                                lidx_q  <= lidx_q + 8'd1;
                                if (32'(lidx_q) + 32'd2 < NUM_LEDS) begin
                                    addr_q   <= lidx_q + 8'd2;
                                    fetch1_q <= 1'b1;
                                end
                            end
                        end else begin
                            shreg_q <= {shreg_q[22:0], 1'b0};
                            bidx_q  <= bidx_q - 5'd1;
                        end
                    end else begin
                        bcnt_q <= bcnt_q + 1'b1;
                    end
                end
                StLatch: begin
                    rcnt_q <= rcnt_q + 1'b1;
                    if (rcnt_q == LatchLast) begin
                        rcnt_q <= '0;
                        done_q <= 1'b1;
                        addr_q <= 8'd0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ws2812_frame_tx.sv
// Directed bench for ws2812_frame_tx: three instances (1, 4 and 255 LEDs) checked bit by bit
// against hand-computed GRB words, plus start-ignore, mid-frame reset and snapshot scenarios.
`timescale 1ns/1ps
module tb_ws2812_frame_tx;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst = 1'b1;
    logic start = 1'b0;
    int   sel = 1;
    int   data_mode = 0;
    int   n_checks = 0;
    int   n_fail = 0;

    logic [23:0] exp_word [0:254];

    logic        one_start, four_start, big_start;
    logic [7:0]  one_addr, four_addr, big_addr;
    logic [23:0] one_data, four_data, big_data;
    logic        one_dout, four_dout, big_dout;
    logic        one_busy, four_busy, big_busy;
    logic        one_done, four_done, big_done;

    logic        m_dout, m_busy, m_done;
    logic [7:0]  m_addr;

    assign one_start  = start && (sel == 0);
    assign four_start = start && (sel == 1);
    assign big_start  = start && (sel == 2);
    assign one_data   = 24'hFF00A5;

    ws2812_frame_tx #(.NUM_LEDS(1)) u_one (
        .clk(clk), .rst(rst), .start(one_start), .led_addr(one_addr), .led_data(one_data),
        .dout(one_dout), .busy(one_busy), .done(one_done)
    );
    ws2812_frame_tx #(.NUM_LEDS(4)) u_four (
        .clk(clk), .rst(rst), .start(four_start), .led_addr(four_addr), .led_data(four_data),
        .dout(four_dout), .busy(four_busy), .done(four_done)
    );
    ws2812_frame_tx #(.NUM_LEDS(255), .T0H(1), .T1H(2), .TBIT(4), .TRESET(10)) u_big (
        .clk(clk), .rst(rst), .start(big_start), .led_addr(big_addr), .led_data(big_data),
        .dout(big_dout), .busy(big_busy), .done(big_done)
    );

    // Registered upstream mux: data follows the address one clock later.
    always @(posedge clk) begin
        if (data_mode == 1)      four_data <= 24'h000000;
        else if (data_mode == 2) four_data <= 24'hFFFFFF;
        else                     four_data <= {3{four_addr}};
        big_data <= {3{big_addr}};
    end

    always_comb begin
        m_dout = four_dout; m_busy = four_busy; m_done = four_done; m_addr = four_addr;
        if (sel == 0) begin
            m_dout = one_dout; m_busy = one_busy; m_done = one_done; m_addr = one_addr;
        end else if (sel == 2) begin
            m_dout = big_dout; m_busy = big_busy; m_done = big_done; m_addr = big_addr;
        end
    end

    // Starts one frame on the selected instance and checks every bit, the latch and done.
    task automatic run_frame(input string name, input int nl, input int tb, input int t0,
                             input int t1, input int tr, input int poke_at,
                             input bit poke_start, input bit poke_flip);
        int hi, bad_bits, first_bad, bad_hi, s, spurious, bad_steps, low_bad, exp_h, idle_bad;
        bit shape_ok;
        logic [7:0] last_addr, max_addr;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        n_checks++;
        if (m_busy !== 1'b1 || m_addr !== 8'd0) begin
            n_fail++;
            $display("FAIL %s busy_rise: busy=%b addr=%0d want busy=1 addr=0", name, m_busy, m_addr);
        end
        @(negedge clk);
        n_checks++;
        if (m_dout !== 1'b0 || m_busy !== 1'b1) begin
            n_fail++;
            $display("FAIL %s prime: dout=%b busy=%b want 0/1", name, m_dout, m_busy);
        end
        @(negedge clk);
        n_checks++;
        if (m_dout !== 1'b1) begin
            n_fail++;
            $display("FAIL %s first_high_latency: dout=%b want 1", name, m_dout);
        end
        s = 0; spurious = 0; bad_steps = 0;
        last_addr = m_addr; max_addr = m_addr;
        for (int led = 0; led < nl; led++) begin
            bad_bits = 0; first_bad = -1; bad_hi = 0;
            for (int b = 0; b < 24; b++) begin
                exp_h = exp_word[led][23-b] ? t1 : t0;
                hi = 0; shape_ok = 1'b1;
                for (int c = 0; c < tb; c++) begin
                    if (s != 0) @(negedge clk);
                    start = 1'b0;
                    if (m_dout === 1'b1) hi++;
                    if (m_dout !== (c < exp_h)) shape_ok = 1'b0;
                    if (m_done !== 1'b0) spurious++;
                    if (m_addr !== last_addr) begin
                        if (m_addr !== last_addr + 8'd1) bad_steps++;
                        last_addr = m_addr;
                    end
                    if (m_addr > max_addr) max_addr = m_addr;
                    if (s == poke_at) begin
                        if (poke_start) start = 1'b1;
                        if (poke_flip) data_mode = 2;
                    end
                    s++;
                end
                if (!shape_ok) begin
                    bad_bits++;
                    if (first_bad < 0) begin first_bad = b; bad_hi = hi; end
                end
            end
            n_checks++;
            if (bad_bits !== 0) begin
                n_fail++;
                $display("FAIL %s led%0d_bits: %0d bad bits, first bit %0d high %0d cycles, word %h",
                         name, led, bad_bits, first_bad, bad_hi, exp_word[led]);
            end
        end
        low_bad = 0;
        for (int r = 0; r < tr; r++) begin
            @(negedge clk);
            start = 1'b0;
            if (m_dout !== 1'b0 || m_done !== 1'b0 || m_busy !== 1'b1) low_bad++;
        end
        n_checks++;
        if (low_bad !== 0) begin
            n_fail++;
            $display("FAIL %s latch_low: %0d bad latch cycles, want 0", name, low_bad);
        end
        @(negedge clk);
        n_checks++;
        if (m_done !== 1'b1 || m_busy !== 1'b0 || m_addr !== 8'd0) begin
            n_fail++;
            $display("FAIL %s done_timing: done=%b busy=%b addr=%0d want 1/0/0",
                     name, m_done, m_busy, m_addr);
        end
        if (poke_start) start = 1'b1;
        @(negedge clk); start = 1'b0;
        n_checks++;
        if (m_done !== 1'b0) begin
            n_fail++;
            $display("FAIL %s done_width: done=%b want 0", name, m_done);
        end
        n_checks++;
        if (spurious !== 0 || bad_steps !== 0) begin
            n_fail++;
            $display("FAIL %s frame_ctrl: early dones=%0d bad addr steps=%0d want 0/0",
                     name, spurious, bad_steps);
        end
        n_checks++;
        if (max_addr !== 8'(nl - 1)) begin
            n_fail++;
            $display("FAIL %s addr_max: got %0d want %0d", name, max_addr, nl - 1);
        end
        if (poke_start) begin
            idle_bad = 0;
            repeat (20) begin
                @(negedge clk);
                if (m_busy !== 1'b0 || m_done !== 1'b0) idle_bad++;
            end
            n_checks++;
            if (idle_bad !== 0) begin
                n_fail++;
                $display("FAIL %s start_on_done: %0d busy/done cycles, want 0", name, idle_bad);
            end
        end
    endtask

    task automatic test_reset();
        #1 rst = 1'b0;
        #1;
        n_checks++;
        if (four_dout !== 1'b0 || four_busy !== 1'b0 || four_done !== 1'b0 || four_addr !== 8'd0
            || one_dout !== 1'b0 || big_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state: dout=%b busy=%b done=%b addr=%0d want 0/0/0/0",
                     four_dout, four_busy, four_done, four_addr);
        end
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++;
        if (four_busy !== 1'b0 || four_dout !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_after_reset: busy=%b dout=%b want 0/0", four_busy, four_dout);
        end
    endtask

    task automatic test_single_led();
        sel = 0;
        exp_word[0] = 24'hFF00A5;
        run_frame("single_led", 1, 63, 20, 40, 3000, -1, 1'b0, 1'b0);
    endtask

    task automatic test_four_leds();
        sel = 1; data_mode = 0;
        for (int i = 0; i < 4; i++) exp_word[i] = {3{8'(i)}};
        run_frame("four_leds", 4, 63, 20, 40, 3000, -1, 1'b0, 1'b0);
    endtask

    task automatic test_start_ignored();
        sel = 1; data_mode = 0;
        for (int i = 0; i < 4; i++) exp_word[i] = {3{8'(i)}};
        run_frame("start_ignored", 4, 63, 20, 40, 3000, 500, 1'b1, 1'b0);
        run_frame("second_frame", 4, 63, 20, 40, 3000, -1, 1'b0, 1'b0);
    endtask

    task automatic test_reset_mid_frame();
        int dones;
        sel = 1; data_mode = 0; dones = 0;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        repeat (2) @(negedge clk);
        // LED 2 starts 2*24*63 cycles after the first high; 10 cycles in is inside a '0' high.
        repeat (3034) begin
            @(negedge clk);
            if (m_done === 1'b1) dones++;
        end
        n_checks++;
        if (m_dout !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_mid_precond: dout=%b want 1", m_dout);
        end
        #2 rst = 1'b0;
        #1;
        n_checks++;
        if (four_dout !== 1'b0 || four_busy !== 1'b0 || four_addr !== 8'd0) begin
            n_fail++;
            $display("FAIL rst_mid_async: dout=%b busy=%b addr=%0d want 0/0/0",
                     four_dout, four_busy, four_addr);
        end
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (50) begin
            @(negedge clk);
            if (four_done === 1'b1 || four_busy === 1'b1) dones++;
        end
        n_checks++;
        if (dones !== 0) begin
            n_fail++;
            $display("FAIL rst_mid_no_done: %0d done/busy cycles, want 0", dones);
        end
        for (int i = 0; i < 4; i++) exp_word[i] = {3{8'(i)}};
        run_frame("after_reset", 4, 63, 20, 40, 3000, -1, 1'b0, 1'b0);
    endtask

    task automatic test_zero_snapshot();
        sel = 1; data_mode = 1;
        exp_word[0] = 24'h000000;
        exp_word[1] = 24'h000000;
        exp_word[2] = 24'hFFFFFF;
        exp_word[3] = 24'hFFFFFF;
        run_frame("zero_snapshot", 4, 63, 20, 40, 3000, 100, 1'b0, 1'b1);
        data_mode = 0;
    endtask

    task automatic test_big_strip();
        sel = 2;
        for (int i = 0; i < 255; i++) exp_word[i] = {3{8'(i)}};
        run_frame("big_strip", 255, 4, 1, 2, 10, -1, 1'b0, 1'b0);
        sel = 1;
    endtask

    initial begin
        test_reset();
        test_single_led();
        test_four_leds();
        test_start_ignored();
        test_reset_mid_frame();
        test_zero_snapshot();
        test_big_strip();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
